// File: rtl/tiger_branch_predict_if.sv
// Fetch/execute interface of the Tiger next-PC / branch unit.
// slave : the branch unit (consumes pipeline state, produces fetch PCs).
// master: the pipeline side.
// Ports:
//   stall, exception                   pipeline control
//   fetch_pc, nextpc                   fetch address (registered / combinational)
//   pred_taken, pred_target            BTB prediction for fetch_pc
//   ex_valid, ex_pc, instr, control    execute-stage instruction
//   rs, rt                             execute-stage operands
//   ex_pred_taken, ex_pred_target      prediction carried down to execute
//   mispredict                         redirect / flush pulse
//   branchout, branchDelay, epc        link address, delay-slot flag, exception PC
// control layout: [0] BRANCH, [3:1] BRANCHTYPE, [4] JUMP, [5] REGJUMP.
// BRANCHTYPE: 0 LTZ, 1 GEZ, 2 EQ, 3 NE, 4 LEZ, 5 GTZ.
interface tiger_branch_predict_if;
  localparam int unsigned CONTROL_WIDTH = 6;

  logic                     stall;
  logic                     exception;
  logic [31:0]              fetch_pc;
  logic [31:0]              nextpc;
  logic                     pred_taken;
  logic [31:0]              pred_target;
  logic                     ex_valid;
  logic [31:0]              ex_pc;
  logic [31:0]              instr;
  logic [CONTROL_WIDTH-1:0] control;
  logic [31:0]              rs;
  logic [31:0]              rt;
  logic                     ex_pred_taken;
  logic [31:0]              ex_pred_target;
  logic                     mispredict;
  logic [31:0]              branchout;
  logic                     branchDelay;
  logic [31:0]              epc;

  modport slave (
    input  stall, exception, ex_valid, ex_pc, instr, control, rs, rt,
           ex_pred_taken, ex_pred_target,
    output fetch_pc, nextpc, pred_taken, pred_target, mispredict,
           branchout, branchDelay, epc
  );

  modport master (
    output stall, exception, ex_valid, ex_pc, instr, control, rs, rt,
           ex_pred_taken, ex_pred_target,
    input  fetch_pc, nextpc, pred_taken, pred_target, mispredict,
           branchout, branchDelay, epc
  );
endinterface

// File: rtl/tiger_branch_predict.sv
// Next-PC / branch unit for the Tiger MIPS core with a direct-mapped BTB.
// Predicted-taken branches redirect fetch right after their delay slot;
// execute resolves branches/jumps, flags mispredictions and redirects fetch.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bp     tiger_branch_predict_if.slave (fetch, execute and exception signals)
module tiger_branch_predict #(
  parameter int unsigned IDX_BITS   = 6,
  parameter int unsigned TAG_BITS   = 8,
  parameter logic [1:0]  CTR_INIT   = 2'd2,
  parameter bit          PREDICT_EN = 1'b1,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter logic [31:0] EXC_ADDR   = 32'h8000_0180
) (
  input logic                   clk,
  input logic                   reset,
  tiger_branch_predict_if.slave bp
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned TAG_LO  = IDX_BITS + 2;
  localparam int unsigned TAG_HI  = IDX_BITS + TAG_BITS + 1;

  localparam logic [2:0] BT_LTZ = 3'd0;
  localparam logic [2:0] BT_GEZ = 3'd1;
  localparam logic [2:0] BT_EQ  = 3'd2;
  localparam logic [2:0] BT_NE  = 3'd3;
  localparam logic [2:0] BT_LEZ = 3'd4;
  localparam logic [2:0] BT_GTZ = 3'd5;

  // ---------------- execute-stage resolution ----------------
  logic        is_branch, is_jump, is_regjump;
  logic [2:0]  br_type;
  logic        rs_neg, rs_zero, cond;
  logic        act_taken;
  logic [31:0] br_target, j_target, act_target, redirect;
  logic        resolve, mispredict;
  logic        unused_instr;

  assign is_branch  = bp.control[0];
  assign br_type    = bp.control[3:1];
  assign is_jump    = bp.control[4];
  assign is_regjump = bp.control[5];
  assign rs_neg     = bp.rs[31];
  assign rs_zero    = (bp.rs == 32'd0);
  assign unused_instr = ^bp.instr[31:26];

  // Branch condition from the decoded branch type.
  always_comb begin
    cond = 1'b0;
    case (br_type)
      BT_LTZ:  cond = rs_neg;
      BT_GEZ:  cond = !rs_neg;
      BT_EQ:   cond = (bp.rs == bp.rt);
      BT_NE:   cond = (bp.rs != bp.rt);
      BT_LEZ:  cond = rs_neg || rs_zero;
      BT_GTZ:  cond = !rs_neg && !rs_zero;
      default: cond = 1'b0;
    endcase
  end

  assign br_target  = bp.ex_pc + 32'd4 + {{14{bp.instr[15]}}, bp.instr[15:0], 2'b00};
  assign j_target   = {bp.ex_pc[31:28], bp.instr[25:0], 2'b00};
  assign act_taken  = (is_branch && cond) || is_jump || is_regjump;
  assign act_target = is_regjump ? bp.rs : (is_jump ? j_target : br_target);
  assign redirect   = act_taken ? act_target : bp.ex_pc + 32'd8;

  assign resolve    = bp.ex_valid && !bp.stall && !reset;
  assign mispredict = resolve &&
                      ((act_taken != bp.ex_pred_taken) ||
                       (act_taken && (act_target != bp.ex_pred_target)));

  // ---------------- BTB storage ----------------
  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic [1:0]          btb_ctr    [ENTRIES];

  // ---------------- fetch-side lookup ----------------
  logic [31:0]         fetch_pc_q, nextpc_c;
  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic                pred_taken_c;
  logic [31:0]         pred_target_c;
  logic                pend_q;
  logic [31:0]         pend_tgt_q;

  assign f_idx         = fetch_pc_q[IDX_BITS+1:2];
  assign f_tag         = fetch_pc_q[TAG_HI:TAG_LO];
  assign pred_taken_c  = PREDICT_EN && btb_valid[f_idx] &&
                         (btb_tag[f_idx] == f_tag) && btb_ctr[f_idx][1];
  assign pred_target_c = btb_target[f_idx];

  // Next fetch address, highest priority first.
  always_comb begin
    nextpc_c = fetch_pc_q + 32'd4;
    if (reset)              nextpc_c = BOOT_ADDR;
    else if (bp.stall)      nextpc_c = fetch_pc_q;
    else if (bp.exception)  nextpc_c = EXC_ADDR;
    else if (mispredict)    nextpc_c = redirect;
    else if (pend_q)        nextpc_c = pend_tgt_q;
  end

  always_ff @(posedge clk) begin
    fetch_pc_q <= nextpc_c;
  end

  // Pending redirect: armed by a predicted-taken fetch, consumed one fetch
  // later so the delay slot is fetched first. Redirects cancel it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else if (!bp.stall) begin
      if (bp.exception || mispredict || pend_q) begin
        pend_q <= 1'b0;
      end else if (pred_taken_c) begin
        pend_q     <= 1'b1;
        pend_tgt_q <= pred_target_c;
      end
    end
  end

  // ---------------- BTB update (one cycle after resolve) ----------------
  logic                upd_v_q, upd_taken_q, upd_jump_q;
  logic [IDX_BITS-1:0] upd_idx_q;
  logic [TAG_BITS-1:0] upd_tag_q;
  logic [31:0]         upd_target_q;
  logic                u_hit, do_write;
  logic [1:0]          ctr_cur, ctr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_v_q <= 1'b0;
    end else if (!bp.stall) begin
      upd_v_q      <= bp.ex_valid && (is_branch || is_jump) && !is_regjump;
      upd_idx_q    <= bp.ex_pc[IDX_BITS+1:2];
      upd_tag_q    <= bp.ex_pc[TAG_HI:TAG_LO];
      upd_taken_q  <= act_taken;
      upd_jump_q   <= is_jump;
      upd_target_q <= act_target;
    end
  end

  assign do_write = upd_v_q && !bp.stall && !reset;
  assign u_hit    = btb_valid[upd_idx_q] && (btb_tag[upd_idx_q] == upd_tag_q);
  assign ctr_cur  = btb_ctr[upd_idx_q];

  // Saturating 2-bit counter step.
  always_comb begin
    ctr_next = ctr_cur;
    if (upd_taken_q) ctr_next = (ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1;
    else             ctr_next = (ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (do_write && (u_hit || upd_taken_q)) begin
      btb_valid[upd_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      if (u_hit) begin
        btb_ctr[upd_idx_q] <= ctr_next;
        if (upd_taken_q) btb_target[upd_idx_q] <= upd_target_q;
      end else if (upd_taken_q) begin
        btb_tag[upd_idx_q]    <= upd_tag_q;
        btb_target[upd_idx_q] <= upd_target_q;
        btb_ctr[upd_idx_q]    <= upd_jump_q ? 2'd3 : CTR_INIT;
      end
    end
  end

  // ---------------- link / delay-slot / EPC ----------------
  logic        bd_q;
  logic [31:0] branchout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bd_q        <= 1'b0;
      branchout_q <= 32'd0;
    end else if (!bp.stall) begin
      bd_q        <= bp.ex_valid && (is_branch || is_jump || is_regjump);
      branchout_q <= bp.ex_pc + 32'd8;
    end
  end

  assign bp.fetch_pc    = fetch_pc_q;
  assign bp.nextpc      = nextpc_c;
  assign bp.pred_taken  = pred_taken_c;
  assign bp.pred_target = pred_target_c;
  assign bp.mispredict  = mispredict;
  assign bp.branchout   = branchout_q;
  assign bp.branchDelay = bd_q;
  assign bp.epc         = bd_q ? bp.ex_pc - 32'd4 : bp.ex_pc;

endmodule

// File: tb/tb_tiger_branch_predict.sv
// Bench for tiger_branch_predict: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_tiger_branch_predict;

  localparam logic [31:0] BOOT   = 32'h0000_0000;
  localparam logic [31:0] EXC    = 32'h8000_0180;
  localparam logic [5:0]  C_NONE = 6'b000000;
  localparam logic [5:0]  C_J    = 6'b010000;
  localparam logic [5:0]  C_JR   = 6'b100000;
  localparam logic [5:0]  C_BEQ  = 6'b000101;
  localparam logic [5:0]  C_BNE  = 6'b000111;
  localparam logic [31:0] I_BEQ  = 32'h1085_0004;  // beq imm=4
  localparam logic [31:0] I_BNE  = 32'h1485_0003;  // bne imm=3
  localparam logic [31:0] I_JR   = 32'h0080_0008;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tiger_branch_predict_if bp ();
  tiger_branch_predict dut (.clk(clk), .reset(reset), .bp(bp));

  int unsigned passed = 0;
  int unsigned total  = 0;

  // ---------------- behavioural model state ----------------
  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] tgt;
    bit          jump;
  } upd_t;

  bit          m_known = 1'b0;
  logic [31:0] m_fetch, m_pend_tgt, m_bo;
  bit          m_pend, m_bd;
  bit          m_v   [64];
  logic [7:0]  m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];
  upd_t        m_q [$];

  bit          d_taken, e_mis, e_ptaken;
  logic [31:0] d_tgt, e_next, e_ptgt, e_epc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural outcome of an execute-stage instruction.
  function automatic void actual(input logic [31:0] pc, ins, rsv, rtv, input logic [5:0] ctl,
                                 output bit tk, output logic [31:0] tg);
    int signed s;
    int        off;
    bit        c;
    s   = $signed(rsv);
    off = $signed(ins[15:0]);
    case (int'(ctl[3:1]))
      0: c = (s < 0);
      1: c = (s >= 0);
      2: c = (rsv == rtv);
      3: c = (rsv != rtv);
      4: c = (s <= 0);
      5: c = (s > 0);
      default: c = 1'b0;
    endcase
    tk = ctl[5] || ctl[4] || (ctl[0] && c);
    if (ctl[5])      tg = rsv;
    else if (ctl[4]) tg = (pc & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    else             tg = pc + 32'(4 + off * 4);
  endfunction

  task automatic model_eval();
    int         li;
    logic [7:0] lt;
    actual(bp.ex_pc, bp.instr, bp.rs, bp.rt, bp.control, d_taken, d_tgt);
    e_mis = !reset && bp.ex_valid && !bp.stall &&
            ((d_taken != bp.ex_pred_taken) || (d_taken && (d_tgt != bp.ex_pred_target)));
    li = int'((m_fetch / 4) % 64);
    lt = 8'((m_fetch / 256) % 256);
    e_ptaken = m_v[li] && (m_tag[li] == lt) && (m_ctr[li] >= 2);
    e_ptgt   = m_tgt[li];
    if (reset)             e_next = BOOT;
    else if (bp.stall)     e_next = m_fetch;
    else if (bp.exception) e_next = EXC;
    else if (e_mis)        e_next = d_taken ? d_tgt : bp.ex_pc + 32'd8;
    else if (m_pend)       e_next = m_pend_tgt;
    else                   e_next = m_fetch + 32'd4;
    e_epc = m_bd ? bp.ex_pc - 32'd4 : bp.ex_pc;
  endtask

  task automatic apply_update(input upd_t u);
    int         i;
    logic [7:0] t;
    i = int'((u.pc / 4) % 64);
    t = 8'((u.pc / 256) % 256);
    if (m_v[i] && m_tag[i] == t) begin
      if (u.taken) begin
        m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = u.tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (u.taken) begin
      m_v[i]   = 1'b1;
      m_tag[i] = t;
      m_tgt[i] = u.tgt;
      m_ctr[i] = u.jump ? 3 : 2;
    end
  endtask

  task automatic model_next();
    upd_t u;
    if (reset) begin
      m_known = 1'b1;
      foreach (m_v[i]) m_v[i] = 1'b0;
      m_pend  = 1'b0;
      m_bd    = 1'b0;
      m_bo    = 32'd0;
      m_q.delete();
      m_fetch = BOOT;
    end else begin
      m_fetch = e_next;
      if (!bp.stall) begin
        if (m_q.size() > 0) apply_update(m_q.pop_front());
        if (bp.ex_valid && (bp.control[0] || bp.control[4]) && !bp.control[5]) begin
          u.pc = bp.ex_pc; u.taken = d_taken; u.tgt = d_tgt; u.jump = bp.control[4];
          m_q.push_back(u);
        end
        if (bp.exception || e_mis || m_pend) m_pend = 1'b0;
        else if (e_ptaken) begin
          m_pend     = 1'b1;
          m_pend_tgt = e_ptgt;
        end
        m_bd = bp.ex_valid && (bp.control[0] || bp.control[4] || bp.control[5]);
        m_bo = bp.ex_pc + 32'd8;
      end
    end
  endtask

  // Compare every DUT output against the model, away from the clock edge.
  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("nextpc", bp.nextpc, e_next);
    chk("mispredict", 32'(bp.mispredict), 32'(e_mis));
    if (m_known) begin
      chk("fetch_pc", bp.fetch_pc, m_fetch);
      chk("branchDelay", 32'(bp.branchDelay), 32'(m_bd));
      chk("branchout", bp.branchout, m_bo);
      chk("epc", bp.epc, e_epc);
      chk("pred_taken", 32'(bp.pred_taken), 32'(e_ptaken));
      if (e_ptaken) chk("pred_target", bp.pred_target, e_ptgt);
    end
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b0; bp.stall = 1'b0; bp.exception = 1'b0;
    bp.ex_valid = 1'b0; bp.ex_pc = 32'd0; bp.instr = 32'd0; bp.control = C_NONE;
    bp.rs = 32'd0; bp.rt = 32'd0; bp.ex_pred_taken = 1'b0; bp.ex_pred_target = 32'd0;
  endtask

  task automatic set_res(input logic [31:0] pc, ins, input logic [5:0] ctl,
                         input logic [31:0] a, b, input logic pt, input logic [31:0] ptg);
    set_idle();
    bp.ex_valid = 1'b1; bp.ex_pc = pc; bp.instr = ins; bp.control = ctl;
    bp.rs = a; bp.rt = b; bp.ex_pred_taken = pt; bp.ex_pred_target = ptg;
  endtask

  // Force fetch to addr next cycle via a false-prediction flush.
  task automatic steer_cycle(input logic [31:0] addr);
    set_res(addr - 32'd8, 32'd0, C_NONE, 32'd0, 32'd0, 1'b1, 32'd0);
    sample(); advance();
  endtask

  task automatic idle_cycle();
    set_idle(); sample(); advance();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd5;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      default: return 32'($urandom_range(0, 63)) * 32'd4;
    endcase
  endfunction

  task automatic random_cycle();
    int          kind, off;
    logic [31:0] ins;
    logic [5:0]  ctl;
    bit          tk;
    logic [31:0] tg;
    set_idle();
    reset        = ($urandom_range(0, 199) == 0);
    bp.stall     = ($urandom_range(0, 99) < 12);
    bp.exception = ($urandom_range(0, 99) < 4);
    bp.ex_valid  = ($urandom_range(0, 99) < 80);
    bp.ex_pc     = 32'($urandom_range(0, 63)) * 32'd4;
    kind = int'($urandom_range(0, 9));
    ins  = 32'($urandom);
    if (kind < 2) ctl = C_NONE;
    else if (kind < 7) begin
      ctl = 6'(($urandom_range(0, 5) * 2) + 1);
      off = int'($urandom_range(0, 40)) - 20;
      ins = {ins[31:16], 16'(off)};
    end else if (kind < 9) begin
      ctl = C_J;
      ins = {ins[31:26], 26'($urandom_range(0, 63))};
    end else ctl = C_JR;
    bp.control = ctl;
    bp.instr   = ins;
    bp.rs      = pick_val();
    bp.rt      = ($urandom_range(0, 1) == 0) ? bp.rs : pick_val();
    actual(bp.ex_pc, ins, bp.rs, bp.rt, ctl, tk, tg);
    case ($urandom_range(0, 3))
      0, 1: begin bp.ex_pred_taken = tk;  bp.ex_pred_target = tg; end
      2:    begin bp.ex_pred_taken = !tk; bp.ex_pred_target = tg; end
      default: begin bp.ex_pred_taken = 1'b1; bp.ex_pred_target = tg + 32'd4; end
    endcase
    sample(); advance();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    sample(); advance();
    sample();
    chk("rst_fetch_pc", bp.fetch_pc, BOOT);
    chk("rst_branchDelay", 32'(bp.branchDelay), 32'd0);
    chk("rst_mispredict", 32'(bp.mispredict), 32'd0);
    advance();

    // Cold BEQ at 0x100 taken to 0x114, then a predicted pass.
    set_res(32'h100, I_BEQ, C_BEQ, 32'd5, 32'd5, 1'b0, 32'd0);
    sample();
    chk("cold_beq_mispredict", 32'(bp.mispredict), 32'd1);
    chk("cold_beq_nextpc", bp.nextpc, 32'h114);
    advance();
    steer_cycle(32'h100);
    set_idle(); sample();
    chk("warm_fetch", bp.fetch_pc, 32'h100);
    chk("warm_pred_taken", 32'(bp.pred_taken), 32'd1);
    chk("warm_pred_target", bp.pred_target, 32'h114);
    chk("warm_delay_slot", bp.nextpc, 32'h104);
    advance();
    set_res(32'h100, I_BEQ, C_BEQ, 32'd5, 32'd5, 1'b1, 32'h114);
    sample();
    chk("warm_resolve_ok", 32'(bp.mispredict), 32'd0);
    chk("warm_target_next", bp.nextpc, 32'h114);
    advance();
    set_idle(); sample();
    chk("warm_target_fetch", bp.fetch_pc, 32'h114);
    advance();

    // Hysteresis: ctr 3 -> 2 still predicts taken; two more -> 0.
    set_res(32'h100, I_BEQ, C_BEQ, 32'd5, 32'd6, 1'b1, 32'h114);
    sample();
    chk("hyst_mispredict", 32'(bp.mispredict), 32'd1);
    chk("hyst_redirect", bp.nextpc, 32'h108);
    advance();
    idle_cycle();
    steer_cycle(32'h100);
    set_idle(); sample();
    chk("hyst_ctr2_taken", 32'(bp.pred_taken), 32'd1);
    advance();
    set_res(32'h100, I_BEQ, C_BEQ, 32'd5, 32'd6, 1'b1, 32'h114);
    sample(); advance();
    set_res(32'h100, I_BEQ, C_BEQ, 32'd5, 32'd6, 1'b0, 32'd0);
    sample();
    chk("hyst_nt_nt_ok", 32'(bp.mispredict), 32'd0);
    advance();
    idle_cycle();
    steer_cycle(32'h100);
    set_idle(); sample();
    chk("hyst_ctr0_fetch", bp.fetch_pc, 32'h100);
    chk("hyst_ctr0_not_taken", 32'(bp.pred_taken), 32'd0);
    advance();

    // Retrain to ctr 2 and stall with the pending redirect armed.
    set_res(32'h100, I_BEQ, C_BEQ, 32'd5, 32'd5, 1'b0, 32'd0);
    sample(); advance();
    set_res(32'h100, I_BEQ, C_BEQ, 32'd5, 32'd5, 1'b0, 32'd0);
    sample(); advance();
    idle_cycle();
    steer_cycle(32'h100);
    set_idle(); sample();
    chk("stall_pre_pred", 32'(bp.pred_taken), 32'd1);
    advance();
    for (int k = 0; k < 3; k++) begin
      set_res(32'h40, I_BEQ, C_BEQ, 32'd7, 32'd7, 1'b0, 32'd0);
      bp.stall = 1'b1;
      sample();
      chk("stall_fetch_hold", bp.fetch_pc, 32'h104);
      chk("stall_nextpc_hold", bp.nextpc, 32'h104);
      chk("stall_no_mispredict", 32'(bp.mispredict), 32'd0);
      advance();
    end
    set_idle(); sample();
    chk("stall_release_slot", bp.fetch_pc, 32'h104);
    chk("stall_release_pend", bp.nextpc, 32'h114);
    advance();
    set_idle(); sample();
    chk("stall_release_target", bp.fetch_pc, 32'h114);
    advance();

    // Exception together with a mispredict while in a delay slot.
    steer_cycle(32'h100);
    set_res(32'h200, I_BNE, C_BNE, 32'd5, 32'd5, 1'b0, 32'd0);
    sample();
    chk("exc_setup_pred", 32'(bp.pred_taken), 32'd1);
    chk("exc_setup_no_mis", 32'(bp.mispredict), 32'd0);
    advance();
    set_res(32'h204, 32'd0, C_NONE, 32'd0, 32'd0, 1'b1, 32'd0);
    bp.exception = 1'b1;
    sample();
    chk("exc_branchDelay", 32'(bp.branchDelay), 32'd1);
    chk("exc_mispredict", 32'(bp.mispredict), 32'd1);
    chk("exc_nextpc", bp.nextpc, EXC);
    chk("exc_epc", bp.epc, 32'h200);
    advance();
    set_idle(); sample();
    chk("exc_fetch", bp.fetch_pc, EXC);
    chk("exc_pend_cleared", bp.nextpc, EXC + 32'd4);
    advance();

    // JR to 0x4000 without a prediction.
    set_res(32'h300, I_JR, C_JR, 32'h4000, 32'd0, 1'b0, 32'd0);
    sample();
    chk("jr_mispredict", 32'(bp.mispredict), 32'd1);
    chk("jr_nextpc", bp.nextpc, 32'h4000);
    advance();
    set_idle(); sample();
    chk("jr_branchout", bp.branchout, 32'h308);
    chk("jr_branchDelay", 32'(bp.branchDelay), 32'd1);
    chk("jr_fetch", bp.fetch_pc, 32'h4000);
    advance();
    idle_cycle();
    steer_cycle(32'h300);
    set_idle(); sample();
    chk("jr_no_btb_entry", 32'(bp.pred_taken), 32'd0);
    advance();

    // Randomized traffic in the low (tag 0) region.
    for (int n = 0; n < 3000; n++) random_cycle();

    // Reset over stale BTB contents, then walk every index.
    set_idle();
    reset = 1'b1;
    sample();
    chk("stale_rst_nextpc", bp.nextpc, BOOT);
    advance();
    for (int k = 0; k < 64; k++) begin
      set_idle(); sample();
      chk("stale_fetch", bp.fetch_pc, 32'(k * 4));
      chk("stale_pred_taken", 32'(bp.pred_taken), 32'd0);
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
